// File: rtl/divider_s.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, then a sign-correction cycle (truncating semantics).
module divider_s #(
  parameter int NB_DATA = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic signed [NB_DATA-1:0] i_dividend,
  input  logic signed [NB_DATA-1:0] i_divisor,
  output logic                      o_busy,
  output logic                      o_done,
  output logic signed [NB_DATA-1:0] o_quotient,
  output logic signed [NB_DATA-1:0] o_remainder,
  output logic                      o_div_by_zero,
  output logic                      o_overflow
);

  // state | meaning
  // IDLE  | waiting for i_start
  // ITER  | one restoring shift-subtract step per cycle, NB_DATA steps
  // FIX   | apply signs and special cases, load output registers
  // DONE  | o_done pulse; a start here is accepted back-to-back
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  localparam int CW = $clog2(NB_DATA + 1);
  localparam logic [NB_DATA-1:0] MOST_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_DATA:0]   rem_q, rem_d;
  logic [NB_DATA-1:0] dvd_mag_q, dvd_mag_d;
  logic [NB_DATA-1:0] dvs_mag_q, dvs_mag_d;
  logic [NB_DATA-1:0] dvd_raw_q, dvd_raw_d;
  logic               sgn_dvd_q, sgn_dvd_d;
  logic               sgn_dvs_q, sgn_dvs_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic [NB_DATA-1:0] quo_out_q, quo_out_d;
  logic [NB_DATA-1:0] rem_out_q, rem_out_d;
  logic               dbz_out_q, dbz_out_d;
  logic               ovf_out_q, ovf_out_d;

  logic [NB_DATA-1:0] dvd_neg, dvs_neg, quo_neg, rem_neg;
  logic [NB_DATA:0]   shifted, trial;
  logic               accept;

  assign dvd_neg = '0 - i_dividend;
  assign dvs_neg = '0 - i_divisor;
  assign quo_neg = '0 - dvd_mag_q;
  assign rem_neg = '0 - rem_q[NB_DATA-1:0];

  // Remainder never exceeds 2^(NB_DATA-1)-1 before the shift, so NB_DATA+1
  // bits hold both the shifted value and the trial difference with its sign.
  assign shifted = {rem_q[NB_DATA-1:0], dvd_mag_q[NB_DATA-1]};
  assign trial   = shifted - {1'b0, dvs_mag_q};
  assign accept  = i_start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_mag_d = dvd_mag_q;
    dvs_mag_d = dvs_mag_q;
    dvd_raw_d = dvd_raw_q;
    sgn_dvd_d = sgn_dvd_q;
    sgn_dvs_d = sgn_dvs_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;
    ovf_out_d = ovf_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          dvd_mag_d = i_dividend[NB_DATA-1] ? dvd_neg : i_dividend;
          dvs_mag_d = i_divisor[NB_DATA-1]  ? dvs_neg : i_divisor;
          dvd_raw_d = i_dividend;
          sgn_dvd_d = i_dividend[NB_DATA-1];
          sgn_dvs_d = i_divisor[NB_DATA-1];
          dbz_d     = (i_divisor == '0);
          ovf_d     = (i_dividend == MOST_NEG) && (i_divisor == '1);
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = ITER;
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (!trial[NB_DATA]) begin
          rem_d     = trial;
          dvd_mag_d = {dvd_mag_q[NB_DATA-2:0], 1'b1};
        end else begin
          rem_d     = shifted;
          dvd_mag_d = {dvd_mag_q[NB_DATA-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NB_DATA - 1)) state_d = FIX;
      end
      FIX: begin
        if (dbz_q) begin
          quo_out_d = '1;
          rem_out_d = dvd_raw_q;
        end else begin
          quo_out_d = (sgn_dvd_q ^ sgn_dvs_q) ? quo_neg : dvd_mag_q;
          rem_out_d = sgn_dvd_q ? rem_neg : rem_q[NB_DATA-1:0];
        end
        dbz_out_d = dbz_q;
        ovf_out_d = ovf_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_mag_q <= '0;
      dvs_mag_q <= '0;
      dvd_raw_q <= '0;
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_mag_q <= dvd_mag_d;
      dvs_mag_q <= dvs_mag_d;
      dvd_raw_q <= dvd_raw_d;
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dvs_q <= sgn_dvs_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign o_busy        = (state_q == ITER) || (state_q == FIX);
  assign o_done        = (state_q == DONE);
  assign o_quotient    = quo_out_q;
  assign o_remainder   = rem_out_q;
  assign o_div_by_zero = dbz_out_q;
  assign o_overflow    = ovf_out_q;

endmodule

// File: tb/tb_divider_s.sv
// Bench for divider_s (NB_DATA=4): directed vector table, corner sequences
// for start-while-busy, back-to-back and mid-operation reset, then a full sweep.
module tb_divider_s;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] dividend = '0;
  logic signed [N-1:0] divisor = '0;
  logic                busy, done, dbz, ovf;
  logic signed [N-1:0] quo, rem;

  int total = 0;
  int bad = 0;

  divider_s #(.NB_DATA(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done),
    .o_quotient(quo), .o_remainder(rem),
    .o_div_by_zero(dbz), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic signed [N-1:0] q;
    logic signed [N-1:0] r;
    logic                dz;
    logic                ov;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Start one operation from the current between-edge time and wait for o_done.
  // Returns the number of edges from the start edge to the edge that raised o_done.
  task automatic run_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int eq, er;
    logic edz, eov;

    vecs[0]  = '{4'sd7,  4'sd2,  4'sd3,  4'sd1,  1'b0, 1'b0};
    vecs[1]  = '{-4'sd7, 4'sd2,  -4'sd3, -4'sd1, 1'b0, 1'b0};
    vecs[2]  = '{4'sd7,  -4'sd3, -4'sd2, 4'sd1,  1'b0, 1'b0};
    vecs[3]  = '{-4'sd7, -4'sd3, 4'sd2,  -4'sd1, 1'b0, 1'b0};
    vecs[4]  = '{-4'sd8, -4'sd1, -4'sd8, 4'sd0,  1'b0, 1'b1};
    vecs[5]  = '{-4'sd8, 4'sd1,  -4'sd8, 4'sd0,  1'b0, 1'b0};
    vecs[6]  = '{4'sd5,  4'sd0,  -4'sd1, 4'sd5,  1'b1, 1'b0};
    vecs[7]  = '{4'sd6,  4'sd3,  4'sd2,  4'sd0,  1'b0, 1'b0};
    vecs[8]  = '{4'sd0,  4'sd5,  4'sd0,  4'sd0,  1'b0, 1'b0};
    vecs[9]  = '{-4'sd8, 4'sd3,  -4'sd2, -4'sd2, 1'b0, 1'b0};
    vecs[10] = '{4'sd7,  4'sd7,  4'sd1,  4'sd0,  1'b0, 1'b0};
    vecs[11] = '{-4'sd1, -4'sd8, 4'sd0,  -4'sd1, 1'b0, 1'b0};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quo, 0);
    chk("rst_r", rem, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_lat", i), lat, 5);
      chk($sformatf("vec%0d_q", i), quo, vecs[i].q);
      chk($sformatf("vec%0d_r", i), rem, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dz);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end
    @(posedge clk);
    #1;
    chk("idle_done_low", done, 0);

    // start pulsed during ITER with other operands must be ignored
    dividend = 4'sd7; divisor = 4'sd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign_busy", busy, 1);
    dividend = 4'sd1; divisor = 4'sd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("ign_lat", lat, 5);
    chk("ign_q", quo, 3);
    chk("ign_r", rem, 1);

    // start held high through DONE: second op accepted with no IDLE gap
    @(posedge clk); #1;
    dividend = -4'sd7; divisor = -4'sd3; start = 1'b1;
    @(posedge clk); #1;
    dividend = 4'sd6; divisor = 4'sd3;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("b2b_lat1", lat, 5);
    chk("b2b_q1", quo, 2);
    chk("b2b_r1", rem, -1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_hold_q", quo, 2);
    chk("b2b_hold_r", rem, -1);
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("b2b_period", lat, 6);
    chk("b2b_q2", quo, 2);
    chk("b2b_r2", rem, 0);

    // reset asserted at iteration 2 aborts the op and clears outputs
    run_op(4'sd7, -4'sd3, lat);
    chk("pre_rst_q", quo, -2);
    dividend = 4'sd5; divisor = 4'sd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quo, 0);
    chk("abort_r", rem, 0);
    chk("abort_dbz", dbz, 0);
    #5;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_q_stays", quo, 0);

    // full sweep against a truncating-division model
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        edz = 1'b0;
        eov = 1'b0;
        if (j == 0) begin
          eq = -1; er = i; edz = 1'b1;
        end else if (i == -8 && j == -1) begin
          eq = -8; er = 0; eov = 1'b1;
        end else begin
          eq = i / j; er = i % j;
        end
        run_op(N'(i), N'(j), lat);
        chk($sformatf("sw_%0d_%0d_lat", i, j), lat, 5);
        chk($sformatf("sw_%0d_%0d_q", i, j), quo, eq);
        chk($sformatf("sw_%0d_%0d_r", i, j), rem, er);
        chk($sformatf("sw_%0d_%0d_flags", i, j), {dbz, ovf}, {edz, eov});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
